// File: rtl/cfg_to_iosf_fifo_mc.sv
// Single-clock multi-channel request FIFO: one circular buffer per channel,
// independent pointers/counts, registered status flags, sticky error flags.
module cfg_to_iosf_fifo_mc #(
  parameter int unsigned WIDTH        = 69,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SHOWAHEAD    = 0,
  parameter int unsigned AFULL_THRESH = 12,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     sclr,
  input  logic [WIDTH-1:0]         data,
  input  logic                     wrreq,
  input  logic [CHW-1:0]           wrch,
  input  logic                     rdreq,
  input  logic [CHW-1:0]           rdch,
  output logic [WIDTH-1:0]         q,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH*(AW+1)-1:0] usedw,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int unsigned MAW      = $clog2(NUM_CH * DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_THRESH);

  logic [WIDTH-1:0]  mem_q [NUM_CH*DEPTH];

  logic [AW-1:0]     wr_ptr_q [NUM_CH];
  logic [AW-1:0]     wr_ptr_d [NUM_CH];
  logic [AW-1:0]     rd_ptr_q [NUM_CH];
  logic [AW-1:0]     rd_ptr_d [NUM_CH];
  logic [AW:0]       cnt_q    [NUM_CH];
  logic [AW:0]       cnt_d    [NUM_CH];

  logic [NUM_CH-1:0] empty_q, empty_d;
  logic [NUM_CH-1:0] full_q, full_d;
  logic [NUM_CH-1:0] afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [WIDTH-1:0]  q_q, q_d;

  logic              wr_in_rng_c, rd_in_rng_c;
  logic              wr_ok_c, rd_ok_c;
  logic [CHW-1:0]    wr_idx_c, rd_idx_c;
  logic [MAW-1:0]    wr_addr_c, rd_addr_c;
  logic [NUM_CH-1:0] wr_sel_c, rd_sel_c;

  // Request decode: range check, accept conditions and flat memory addresses
  always_comb begin
    rd_in_rng_c = (32'(rdch) < NUM_CH);
    wr_in_rng_c = (32'(wrch) < NUM_CH);
    rd_idx_c    = rd_in_rng_c ? rdch : '0;
    wr_idx_c    = wr_in_rng_c ? wrch : '0;
    rd_ok_c     = rdreq && rd_in_rng_c && !empty_q[rd_idx_c];
    // A full channel can still take a write when its head is popped this cycle
    wr_ok_c     = wrreq && wr_in_rng_c &&
                  (!full_q[wr_idx_c] || (rd_ok_c && (rd_idx_c == wr_idx_c)));
    rd_addr_c   = MAW'(32'(rd_idx_c) * DEPTH + 32'(rd_ptr_q[rd_idx_c]));
    wr_addr_c   = MAW'(32'(wr_idx_c) * DEPTH + 32'(wr_ptr_q[wr_idx_c]));
  end

  // Per-channel pointer, occupancy and status next-state
  always_comb begin
    wr_sel_c = '0;
    rd_sel_c = '0;
    empty_d  = '0;
    full_d   = '0;
    afull_d  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_sel_c[c] = wr_ok_c && (32'(wr_idx_c) == c);
      rd_sel_c[c] = rd_ok_c && (32'(rd_idx_c) == c);
      wr_ptr_d[c] = wr_ptr_q[c] + AW'(wr_sel_c[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AW'(rd_sel_c[c]);
      cnt_d[c]    = cnt_q[c];
      if (wr_sel_c[c] && !rd_sel_c[c]) begin
        cnt_d[c] = cnt_q[c] + (AW+1)'(1);
      end else if (!wr_sel_c[c] && rd_sel_c[c]) begin
        cnt_d[c] = cnt_q[c] - (AW+1)'(1);
      end
      empty_d[c] = (cnt_d[c] == '0);
      full_d[c]  = (cnt_d[c] == FULL_CNT);
      afull_d[c] = (cnt_d[c] >= AF_CNT);
    end
  end

  // Sticky error flags and registered read data
  always_comb begin
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (wrreq && !wr_ok_c) begin
      ovf_d = 1'b1;
    end
    if (rdreq && !rd_ok_c) begin
      unf_d = 1'b1;
    end
    q_d = q_q;
    if (rd_ok_c) begin
      q_d = mem_q[rd_addr_c];
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clock) begin
    if (sclr) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
      afull_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      q_q     <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      empty_q <= empty_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      q_q     <= q_d;
    end
  end

  // Storage array; contents survive sclr
  always_ff @(posedge clock) begin
    if (wr_ok_c && !sclr) begin
      mem_q[wr_addr_c] <= data;
    end
  end

  // Show-ahead presents the selected channel's head straight from the array
  assign q           = (SHOWAHEAD != 0) ? mem_q[rd_addr_c] : q_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_usedw
    assign usedw[g*(AW+1) +: AW+1] = cnt_q[g];
  end

endmodule

// File: tb/tb_cfg_to_iosf_fifo_mc.sv
// Scoreboard bench: stimulus pushes expected read data, a monitor pops and
// compares q one cycle after each issued read; status is checked inline.
module tb_cfg_to_iosf_fifo_mc;

  localparam int W  = 69;
  localparam int NC = 4;

  logic          clock = 1'b0;
  logic          sclr, wrreq, rdreq, err_clr;
  logic [W-1:0]  data;
  logic [1:0]    wrch, rdch;
  logic [W-1:0]  q;
  logic [NC-1:0] empty, full, afull;
  logic [19:0]   usedw;
  logic          ovf, unf;

  logic          sa_wrreq, sa_rdreq;
  logic [W-1:0]  sa_data, sa_q;
  logic [1:0]    sa_wrch, sa_rdch;
  logic [NC-1:0] sa_empty, sa_full, sa_afull;
  logic [19:0]   sa_usedw;
  logic          sa_ovf, sa_unf;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_exp;
  bit            rd_seen = 1'b0;
  int            n_checks = 0;
  int            n_err = 0;

  always #5 clock = ~clock;

  cfg_to_iosf_fifo_mc #(.WIDTH(W), .DEPTH(16), .NUM_CH(NC), .SHOWAHEAD(0),
                        .AFULL_THRESH(12)) u_dut (
    .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .wrch(wrch),
    .rdreq(rdreq), .rdch(rdch), .q(q), .empty(empty), .full(full),
    .almost_full(afull), .usedw(usedw), .overflow(ovf), .underflow(unf),
    .err_clr(err_clr)
  );

  cfg_to_iosf_fifo_mc #(.WIDTH(W), .DEPTH(16), .NUM_CH(NC), .SHOWAHEAD(1),
                        .AFULL_THRESH(12)) u_dut_sa (
    .clock(clock), .sclr(sclr), .data(sa_data), .wrreq(sa_wrreq), .wrch(sa_wrch),
    .rdreq(sa_rdreq), .rdch(sa_rdch), .q(sa_q), .empty(sa_empty), .full(sa_full),
    .almost_full(sa_afull), .usedw(sa_usedw), .overflow(sa_ovf), .underflow(sa_unf),
    .err_clr(1'b0)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] uw(input int c);
    return usedw[c*5 +: 5];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input bit wr, input logic [1:0] wc, input logic [W-1:0] wd,
                      input bit rd, input logic [1:0] rc, input logic [W-1:0] eq);
    data  = wd;
    wrreq = wr;
    wrch  = wc;
    rdreq = rd;
    rdch  = rc;
    if (rd && !sclr) exp_q.push_back(eq);
    tick();
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  // Record whether a read was issued at this edge
  always @(posedge clock) rd_seen <= rdreq && !sclr;

  // Monitor: compare q against the oldest expectation after each read edge
  always @(negedge clock) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rd_q: got %h with no expected read pending", q);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rd_q", q, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0;
    data = '0; wrch = '0; rdch = '0;
    sa_wrreq = 1'b0; sa_rdreq = 1'b0; sa_data = '0; sa_wrch = '0; sa_rdch = '0;
    tick();
    sclr = 1'b0;
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_q", q, 0);

    // single write / read on ch2
    step(1, 2, 69'h1_2345_6789, 0, 0, 0);
    chk("wr_empty", empty, 4'b1011);
    chk("wr_usedw2", uw(2), 1);
    step(0, 0, 0, 1, 2, 69'h1_2345_6789);
    chk("rd_empty", empty, 4'hF);

    // fill ch1, overflow, drain, underflow
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 69'(i), 0, 0, 0);
      if (i == 10) chk("afull_11", afull[1], 0);
      if (i == 11) chk("afull_12", afull[1], 1);
      if (i == 14) chk("full_15", full[1], 0);
      if (i == 15) chk("full_16", full[1], 1);
    end
    step(1, 1, 69'd99, 0, 0, 0);
    chk("ovf_17th", ovf, 1);
    chk("usedw1_full", uw(1), 16);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 69'(i));
    chk("drain_empty1", empty[1], 1);
    chk("drain_afull1", afull[1], 0);
    step(0, 0, 0, 1, 1, 69'd15);
    chk("unf_17th", unf, 1);

    // clear errors, then simultaneous read/write on full ch0 and empty ch3
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_unf", unf, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 69'(32'h100 + i), 0, 0, 0);
    chk("full0", full[0], 1);
    step(1, 0, 69'h200, 1, 0, 69'h100);
    chk("rw_full_usedw0", uw(0), 16);
    chk("rw_full_full0", full[0], 1);
    chk("rw_full_ovf", ovf, 0);
    step(1, 3, 69'h300, 1, 3, 69'h100);
    chk("rw_empty_unf", unf, 1);
    chk("rw_empty_usedw3", uw(3), 1);
    chk("rw_empty_empty3", empty[3], 0);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("rst2_empty", empty, 4'hF);

    // interleave ch0 / ch3, 40 writes, ch0 pointer wraps
    for (int i = 0; i < 42; i++) begin
      step(i < 40, (i % 2 == 0) ? 2'd0 : 2'd3,
           (i % 2 == 0) ? 69'(32'h1000 + i / 2) : 69'(32'h2000 + i / 2),
           i >= 2, (i % 2 == 0) ? 2'd0 : 2'd3,
           (i % 2 == 0) ? 69'(32'h1000 + (i - 2) / 2) : 69'(32'h2000 + (i - 3) / 2));
      if (i == 20) chk("il_usedw0", uw(0), 1);
    end
    chk("il_empty", empty, 4'hF);
    chk("il_ovf", ovf, 0);
    chk("il_unf", unf, 0);

    // reset mid-burst with errors pending
    for (int i = 0; i < 17; i++) step(1, 1, 69'(i), 0, 0, 0);
    chk("mb_ovf", ovf, 1);
    for (int i = 0; i < 7; i++) step(1, 2, 69'(32'h700 + i), 0, 0, 0);
    chk("mb_usedw2", uw(2), 7);
    sclr = 1'b1;
    step(1, 2, 69'h7ff, 1, 0, 0);
    sclr = 1'b0;
    chk("mb_empty", empty, 4'hF);
    chk("mb_usedw", usedw, 0);
    chk("mb_full", full, 0);
    chk("mb_ovf_clr", ovf, 0);
    chk("mb_unf_clr", unf, 0);
    chk("mb_q", q, 0);

    // drop in the same cycle as err_clr keeps the flag set
    for (int i = 0; i < 16; i++) step(1, 1, 69'(i), 0, 0, 0);
    err_clr = 1'b1;
    step(1, 1, 69'h55, 0, 0, 0);
    err_clr = 1'b0;
    chk("errclr_set_wins", ovf, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_alone", ovf, 0);

    // show-ahead instance
    sa_rdch = 2'd1;
    sa_wrch = 2'd1;
    sa_data = 69'hAA; sa_wrreq = 1'b1;
    tick();
    sa_wrreq = 1'b0;
    chk("sa_first", sa_q, 69'hAA);
    sa_data = 69'hBB; sa_wrreq = 1'b1;
    tick();
    sa_wrreq = 1'b0;
    chk("sa_hold", sa_q, 69'hAA);
    chk("sa_usedw1", sa_usedw[5 +: 5], 2);
    chk("sa_full1", sa_full[1], 0);
    chk("sa_afull1", sa_afull[1], 0);
    sa_rdreq = 1'b1;
    tick();
    sa_rdreq = 1'b0;
    chk("sa_pop", sa_q, 69'hBB);
    sa_rdreq = 1'b1;
    tick();
    sa_rdreq = 1'b0;
    chk("sa_empty1", sa_empty[1], 1);
    chk("sa_no_unf", sa_unf, 0);
    chk("sa_no_ovf", sa_ovf, 0);
    sa_rdreq = 1'b1;
    tick();
    sa_rdreq = 1'b0;
    chk("sa_unf", sa_unf, 1);

    repeat (3) tick();
    chk("scoreboard_drained", 69'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
